fwd_select_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 24 ++
 rtl/fwd_match_prio.sv | 34 +++
 rtl/fwd_select_unit.sv | 110 +++++++++++
 tb/tb_fwd_select_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the EX-stage forwarding control: register width,
// operand-mux select codes and the in-flight slot layout.
package cpu_pkg;

  localparam int unsigned REG_ADDR_W = 4;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;
  localparam logic [1:0] SEL_WB2 = 2'b11;

  typedef struct packed {
    logic                  v;
    logic                  we;
    logic [REG_ADDR_W-1:0] rd;
  } prod_t;

  // Only the MEM slot needs the load flag; past MEM a load's data exists.
  typedef struct packed {
    logic  ld;
    prod_t p;
  } slot_t;

endpackage

// File: rtl/fwd_match_prio.sv
// Priority matcher: one source register against the MEM, WB and post-WB
// producers; the youngest valid writer of that register wins.
module fwd_match_prio
  import cpu_pkg::*;
#(
  parameter logic [REG_ADDR_W-1:0] ZERO_REG = '0
) (
  input  logic [REG_ADDR_W-1:0] i_src,
  input  prod_t                 i_s1,
  input  prod_t                 i_s2,
  input  prod_t                 i_s3,
  output logic [1:0]            o_sel,
  output logic                  o_s1_hit
);

  function automatic logic hit(input prod_t s, input logic [REG_ADDR_W-1:0] r);
    return s.v & s.we & (s.rd == r) & (r != ZERO_REG);
  endfunction

  logic w_h1, w_h2, w_h3;

  assign w_h1     = hit(i_s1, i_src);
  assign w_h2     = hit(i_s2, i_src);
  assign w_h3     = hit(i_s3, i_src);
  assign o_s1_hit = w_h1;

  always_comb begin
    o_sel = SEL_RF;
    if (w_h1)      o_sel = SEL_MEM;
    else if (w_h2) o_sel = SEL_WB;
    else if (w_h3) o_sel = SEL_WB2;
  end

endmodule

// File: rtl/fwd_select_unit.sv
// EX operand-forwarding control with load-use hazard detection.
// Define FWD_STATS_EN to add saturating forward/stall event counters.
module fwd_select_unit #(
  parameter int unsigned           REG_ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter logic [REG_ADDR_W-1:0] ZERO_REG   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic                  ex_we,
  input  logic                  ex_ld,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic                  ex_hold,
  input  logic                  ex_flush,
`ifdef FWD_STATS_EN
  output logic [15:0]           fwd_count,
  output logic [15:0]           stall_count,
`endif
  output logic [1:0]            sel_a,
  output logic [1:0]            sel_b,
  output logic                  hazard
);

  import cpu_pkg::*;

  slot_t r_s1;
  prod_t r_s2;
  prod_t r_s3;
  slot_t w_s1_d;

  logic [1:0] w_sel_a, w_sel_b;
  logic       w_s1_hit_a, w_s1_hit_b;
  logic       w_ld_hit_a, w_ld_hit_b;

  // A held or flushed EX instruction leaves a bubble behind it.
  always_comb begin
    w_s1_d = '0;
    if (!ex_flush && !ex_hold) begin
      w_s1_d.ld   = ex_ld;
      w_s1_d.p.v  = ex_valid;
      w_s1_d.p.we = ex_we;
      w_s1_d.p.rd = ex_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s3 <= r_s2;
      r_s2 <= r_s1.p;
      r_s1 <= w_s1_d;
    end
  end

  fwd_match_prio #(
    .ZERO_REG (ZERO_REG)
  ) u_match_a (
    .i_src    (ex_rs1),
    .i_s1     (r_s1.p),
    .i_s2     (r_s2),
    .i_s3     (r_s3),
    .o_sel    (w_sel_a),
    .o_s1_hit (w_s1_hit_a)
  );

  fwd_match_prio #(
    .ZERO_REG (ZERO_REG)
  ) u_match_b (
    .i_src    (ex_rs2),
    .i_s1     (r_s1.p),
    .i_s2     (r_s2),
    .i_s3     (r_s3),
    .o_sel    (w_sel_b),
    .o_s1_hit (w_s1_hit_b)
  );

  // A load in MEM has no data yet: stall and read nothing from the bypass.
  assign w_ld_hit_a = ex_valid & r_s1.ld & w_s1_hit_a;
  assign w_ld_hit_b = ex_valid & r_s1.ld & w_s1_hit_b;
  assign hazard     = w_ld_hit_a | w_ld_hit_b;
  assign sel_a      = w_ld_hit_a ? SEL_RF : w_sel_a;
  assign sel_b      = w_ld_hit_b ? SEL_RF : w_sel_b;

`ifdef FWD_STATS_EN
  logic [15:0] r_fwd_cnt;
  logic [15:0] r_stall_cnt;
  logic        w_fwd_evt;

  assign w_fwd_evt = ex_valid & ~ex_hold & ((sel_a != SEL_RF) | (sel_b != SEL_RF));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_fwd_evt && (r_fwd_cnt != 16'hFFFF))  r_fwd_cnt   <= r_fwd_cnt + 16'd1;
      if (hazard && (r_stall_cnt != 16'hFFFF))   r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign fwd_count   = r_fwd_cnt;
  assign stall_count = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fwd_select_unit.sv
// Bench for fwd_select_unit: directed scenarios followed by random traffic
// checked against a history-queue model of the three older instructions.
module tb_fwd_select_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ex_valid, ex_we, ex_ld, ex_hold, ex_flush;
  logic [3:0] ex_rd, ex_rs1, ex_rs2;
  logic [1:0] sel_a, sel_b;
  logic       hazard;
`ifdef FWD_STATS_EN
  logic [15:0] fwd_count, stall_count;
`endif

  always #5 clk = ~clk;

  fwd_select_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid    (ex_valid),
    .ex_we       (ex_we),
    .ex_ld       (ex_ld),
    .ex_rd       (ex_rd),
    .ex_rs1      (ex_rs1),
    .ex_rs2      (ex_rs2),
    .ex_hold     (ex_hold),
    .ex_flush    (ex_flush),
`ifdef FWD_STATS_EN
    .fwd_count   (fwd_count),
    .stall_count (stall_count),
`endif
    .sel_a       (sel_a),
    .sel_b       (sel_b),
    .hazard      (hazard)
  );

  typedef struct packed {
    logic       v;
    logic       we;
    logic       ld;
    logic [3:0] rd;
  } ent_t;

  ent_t hist[$];  // hist[0] = one instruction older than EX
  int   n_pass;
  int   n_total;
  int   fwd_m;
  int   stall_m;

  task automatic model_reset();
    hist.delete();
    repeat (3) hist.push_back('0);
    fwd_m   = 0;
    stall_m = 0;
  endtask

  function automatic logic [1:0] pick(input logic [3:0] r, output logic ldhit);
    logic [1:0] s;
    s     = 2'd0;
    ldhit = 1'b0;
    for (int k = 2; k >= 0; k--) begin
      if (hist[k].v && hist[k].we && hist[k].rd == r && r != 4'd0) begin
        s     = 2'(k + 1);
        ldhit = (k == 0) && hist[k].ld;
      end
    end
    return s;
  endfunction

  task automatic exp_out(output logic [1:0] ea, output logic [1:0] eb, output logic ehz);
    logic la, lb;
    ea  = pick(ex_rs1, la);
    eb  = pick(ex_rs2, lb);
    ehz = ex_valid && (la || lb);
    if (ex_valid && la) ea = 2'd0;
    if (ex_valid && lb) eb = 2'd0;
  endtask

  task automatic model_edge();
    logic [1:0] ea, eb;
    logic       ehz;
    ent_t       e;
    if (!rst_n) begin
      model_reset();
      return;
    end
    exp_out(ea, eb, ehz);
    if (ex_valid && !ex_hold && (ea != 0 || eb != 0) && fwd_m < 16'hFFFF) fwd_m++;
    if (ehz && stall_m < 16'hFFFF) stall_m++;
    e = (ex_hold || ex_flush) ? ent_t'(0) : {ex_valid, ex_we, ex_ld, ex_rd};
    hist.push_front(e);
    hist.delete(3);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic we, input logic ld, input logic [3:0] rd,
                       input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic hold, input logic flush);
    ex_valid = v;
    ex_we    = we;
    ex_ld    = ld;
    ex_rd    = rd;
    ex_rs1   = rs1;
    ex_rs2   = rs2;
    ex_hold  = hold;
    ex_flush = flush;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [1:0] ea, eb;
    logic       ehz;
    @(negedge clk);
    exp_out(ea, eb, ehz);
    check({tag, ".hazard"}, 16'(hazard), 16'(ehz));
    if (ex_valid) begin
      check({tag, ".sel_a"}, 16'(sel_a), 16'(ea));
      check({tag, ".sel_b"}, 16'(sel_b), 16'(eb));
    end
`ifdef FWD_STATS_EN
    check({tag, ".fwd_count"}, fwd_count, 16'(fwd_m));
    check({tag, ".stall_count"}, stall_count, 16'(stall_m));
`endif
  endtask

  initial begin
    logic       h;
    logic       ehz;
    logic [1:0] ea, eb;
`ifdef FWD_STATS_EN
    logic [15:0] fsnap;
`endif
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check("reset.sel_a", 16'(sel_a), 16'd0);
    check("reset.sel_b", 16'(sel_b), 16'd0);
    check("reset.hazard", 16'(hazard), 16'd0);
    tick();
    rst_n = 1'b1;

    // Back-to-back ALU producer of r3 seen from each slot in turn.
    drive(1, 1, 0, 3, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 3, 0, 0, 0); @(negedge clk);
    check("b2b.mem", 16'(sel_a), 16'd1); tick();
    drive(1, 0, 0, 0, 0, 3, 0, 0); @(negedge clk);
    check("b2b.wb", 16'(sel_b), 16'd2); tick();
    drive(1, 0, 0, 0, 3, 0, 0, 0); @(negedge clk);
    check("b2b.wb2", 16'(sel_a), 16'd3); tick();
    drive(1, 0, 0, 0, 3, 3, 0, 0); @(negedge clk);
    check("b2b.gone", 16'(sel_a), 16'd0); tick();

    // Producers of r5 in S3 and S1: youngest wins on both operands.
    drive(1, 1, 0, 5, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 1, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 5, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 5, 5, 0, 0); @(negedge clk);
    check("prio.sel_a", 16'(sel_a), 16'd1);
    check("prio.sel_b", 16'(sel_b), 16'd1);
    check("prio.hazard", 16'(hazard), 16'd0); tick();

    // Writes to the zero register are never forwarded.
    drive(1, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0); @(negedge clk);
    check("zero.sel_a", 16'(sel_a), 16'd0); tick();

    // Load-use: stall one cycle, then take WB data.
    drive(1, 1, 1, 7, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 7, 1, 0); @(negedge clk);
    check("ldu.hazard", 16'(hazard), 16'd1);
    check("ldu.sel_b", 16'(sel_b), 16'd0); tick();
    drive(1, 0, 0, 0, 0, 7, 0, 0); @(negedge clk);
    check("ldu.hazard_clr", 16'(hazard), 16'd0);
    check("ldu.sel_b_wb", 16'(sel_b), 16'd2); tick();

    // Flushed producer leaves nothing behind.
    drive(1, 1, 0, 9, 0, 0, 0, 1); tick();
    drive(1, 0, 0, 0, 9, 0, 0, 0); @(negedge clk);
    check("flush.sel_a", 16'(sel_a), 16'd0);
`ifdef FWD_STATS_EN
    fsnap = fwd_count;
`endif
    tick();
`ifdef FWD_STATS_EN
    check("flush.fwd_count", fwd_count, fsnap);
`endif

    // Asynchronous reset mid-stream with a pending load-use hazard.
    drive(1, 1, 1, 4, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 4, 4, 0, 0); @(negedge clk);
    check("rst.pre_hazard", 16'(hazard), 16'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst.hazard", 16'(hazard), 16'd0);
    check("rst.sel_a", 16'(sel_a), 16'd0);
    check("rst.sel_b", 16'(sel_b), 16'd0);
`ifdef FWD_STATS_EN
    check("rst.fwd_count", fwd_count, 16'd0);
    check("rst.stall_count", stall_count, 16'd0);
`endif
    model_reset();
    tick();
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 4, 0, 0, 0); @(negedge clk);
    check("rst.after_sel_a", 16'(sel_a), 16'd0); tick();

    // Random traffic on a narrow register range to force frequent matches.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 2) == 0,
            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            0, $urandom_range(0, 7) == 0);
      exp_out(ea, eb, ehz);
      h = ehz || ($urandom_range(0, 5) == 0);
      ex_hold = h;
      check_model($sformatf("rnd%0d", i));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
